// File: rtl/lcd_rgb_timing.sv
// RGB-panel timing generator: walks an (h_cnt, v_cnt) raster at two CLK per pixel,
// pulls big-endian RGB565 pixels from the byte FIFO and drives the panel 3 CLK behind the counters.
module lcd_rgb_timing #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 48,
  parameter int H_BP     = 40,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 13,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 29,
  parameter int SYNC_POL = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FrameCtrl,
  input  logic        FIFO_Empty,
  input  logic [7:0]  FIFO_RData,
  output logic        FIFO_Re,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic        LCD_PCLK,
  output logic        LCD_HSYNC,
  output logic        LCD_VSYNC,
  output logic        LCD_DE,
  output logic [15:0] LCD_RGB,
  output logic        UNDERFLOW
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT_END  = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        POL        = (SYNC_POL != 0);

  logic        phase, phase_nxt;
  logic [10:0] h_cnt, h_nxt;
  logic [9:0]  v_cnt, v_nxt;
  logic        frame_en, frame_en_cur, frame_start;
  logic        h_act, v_act, rd_req;
  logic        hs_dec, vs_dec;

  // Stage 1: decode of the previous cycle, aligned with FIFO_RData
  logic        s1_phase, s1_re, s1_act, s1_hs, s1_vs;
  // Stage 2: one more cycle of delay for the control outputs
  logic        s2_phase, s2_act, s2_hs, s2_vs;
  logic [7:0]  hi_byte, rd_byte;

  always_comb begin
    phase_nxt = ~phase;
    h_nxt     = h_cnt;
    v_nxt     = v_cnt;
    if (phase) begin
      if (h_cnt == H_LAST) begin
        h_nxt = '0;
        v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      end else begin
        h_nxt = h_cnt + 11'd1;
      end
    end
  end

  // The frame-start cycle itself must already see the freshly sampled gate,
  // otherwise the first high byte of an enabled frame would be skipped.
  assign frame_start  = ~phase && (h_cnt == '0) && (v_cnt == '0);
  assign frame_en_cur = frame_start ? FrameCtrl : frame_en;

  assign h_act   = (h_cnt < H_ACT_END);
  assign v_act   = (v_cnt < V_ACT_END);
  assign rd_req  = h_act & v_act & frame_en_cur & ~RST;
  assign FIFO_Re = rd_req & ~FIFO_Empty;

  assign hs_dec  = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vs_dec  = (v_cnt >= VS_START) && (v_cnt < VS_END);

  assign rd_byte = s1_re ? FIFO_RData : 8'h00;

  always_ff @(posedge CLK) begin
    if (RST) begin
      phase     <= 1'b0;
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_en  <= 1'b0;
      HSYNC     <= 1'b1;
      VSYNC     <= 1'b1;
      UNDERFLOW <= 1'b0;
      s1_phase  <= 1'b0;
      s1_re     <= 1'b0;
      s1_act    <= 1'b0;
      s1_hs     <= 1'b0;
      s1_vs     <= 1'b0;
      s2_phase  <= 1'b0;
      s2_act    <= 1'b0;
      s2_hs     <= 1'b0;
      s2_vs     <= 1'b0;
      hi_byte   <= 8'h00;
      LCD_RGB   <= 16'h0000;
      LCD_DE    <= 1'b0;
      LCD_PCLK  <= 1'b0;
      LCD_HSYNC <= ~POL;
      LCD_VSYNC <= ~POL;
    end else begin
      phase <= phase_nxt;
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
      if (frame_start) frame_en <= FrameCtrl;

      // Computed from the next counter state so the flags line up with h_cnt/v_cnt
      HSYNC <= (h_nxt >= H_ACT_END);
      VSYNC <= (v_nxt >= V_ACT_END);

      if (rd_req && FIFO_Empty) UNDERFLOW <= 1'b1;

      s1_phase <= phase;
      s1_re    <= FIFO_Re;
      s1_act   <= rd_req;
      s1_hs    <= hs_dec;
      s1_vs    <= vs_dec;

      s2_phase <= s1_phase;
      s2_act   <= s1_act;
      s2_hs    <= s1_hs;
      s2_vs    <= s1_vs;

      LCD_PCLK  <= s2_phase;
      LCD_DE    <= s2_act;
      LCD_HSYNC <= ~(s2_hs ^ POL);
      LCD_VSYNC <= ~(s2_vs ^ POL);

      // Byte arriving for a phase-0 read is the high half; phase-1 completes the pixel
      if (!s1_phase) begin
        hi_byte <= rd_byte;
      end else begin
        LCD_RGB <= s1_act ? {hi_byte, rd_byte} : 16'h0000;
      end
    end
  end

endmodule
